// File: rtl/time_set_pkg.sv
// ============================================================================
// Module      : time_set_pkg
// Description : Shared types and constants for the time-set controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_set_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    // Bit positions inside the button / event vector
    localparam int EV_W   = 3;
    localparam int EV_AUM = 0;
    localparam int EV_DIS = 1;
    localparam int EV_SEL = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_EXEC   = 2'd2,
        ST_STROBE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_SELECT = 2'd1,
        CMD_INC    = 2'd2,
        CMD_DEC    = 2'd3
    } cmd_e;

    // Field select wins; simultaneous up and down cancel each other
    function automatic cmd_e decode_cmd(input logic [EV_W-1:0] ev);
        cmd_e cmd;
        cmd = CMD_NOP;
        if (ev[EV_SEL]) begin
            cmd = CMD_SELECT;
        end else if (ev[EV_AUM] ^ ev[EV_DIS]) begin
            cmd = ev[EV_AUM] ? CMD_INC : CMD_DEC;
        end
        return cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detector.sv
// ============================================================================
// Module      : edge_detector
// Description : Per-bit rising-edge detector with registered history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        prev_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/time_set_controller.sv
// ============================================================================
// Module      : time_set_controller
// Description : Button-driven hour/minute/second editor with RTC write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_set_controller
    import time_set_pkg::*;
#(
    parameter int HOUR_MAX = 23,
    parameter int MIN_MAX  = 59,
    parameter int SEC_MAX  = 59
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aumentar,
    input  logic              disminuir,
    input  logic              funct_select,
    input  logic              sync_load,
    input  logic [HOUR_W-1:0] hora_in,
    input  logic [MIN_W-1:0]  minuto_in,
    input  logic [SEC_W-1:0]  segundo_in,
    output logic              chip_select,
    output logic [HOUR_W-1:0] hora,
    output logic [MIN_W-1:0]  minuto,
    output logic [SEC_W-1:0]  segundo,
    output logic [1:0]        field,
    output logic              write_strobe,
    output logic              busy
);

    localparam logic [HOUR_W-1:0] C_HOUR_MAX = HOUR_MAX[HOUR_W-1:0];
    localparam logic [MIN_W-1:0]  C_MIN_MAX  = MIN_MAX[MIN_W-1:0];
    localparam logic [SEC_W-1:0]  C_SEC_MAX  = SEC_MAX[SEC_W-1:0];

    logic [EV_W-1:0]   btn;
    logic [EV_W-1:0]   rise;

    state_e            state_q,   state_d;
    logic [EV_W-1:0]   ev_q,      ev_d;
    cmd_e              cmd_q,     cmd_d;
    field_e            field_q,   field_d;
    logic [HOUR_W-1:0] hora_q,    hora_d;
    logic [MIN_W-1:0]  minuto_q,  minuto_d;
    logic [SEC_W-1:0]  segundo_q, segundo_d;
    logic              strobe_q,  strobe_d;

    assign btn = {funct_select, disminuir, aumentar};

    edge_detector #(
        .WIDTH (EV_W)
    ) u_edge_detector (
        .clk   (clk),
        .rst_n (reset),
        .din   (btn),
        .rise  (rise)
    );

    always_comb begin
        state_d   = state_q;
        ev_d      = ev_q;
        cmd_d     = cmd_q;
        field_d   = field_q;
        hora_d    = hora_q;
        minuto_d  = minuto_q;
        segundo_d = segundo_q;
        strobe_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    ev_d    = rise;
                    state_d = ST_LOCK;
                end else if (sync_load && (field_q == FIELD_NONE)) begin
                    hora_d    = (hora_in    > C_HOUR_MAX) ? C_HOUR_MAX : hora_in;
                    minuto_d  = (minuto_in  > C_MIN_MAX)  ? C_MIN_MAX  : minuto_in;
                    segundo_d = (segundo_in > C_SEC_MAX)  ? C_SEC_MAX  : segundo_in;
                end
            end
            ST_LOCK: begin
                cmd_d   = decode_cmd(ev_q);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_STROBE;
                case (cmd_q)
                    CMD_SELECT: field_d = field_e'(field_q + 2'd1);
                    CMD_INC, CMD_DEC: begin
                        case (field_q)
                            FIELD_HOUR: begin
                                strobe_d = 1'b1;
                                if (cmd_q == CMD_INC) begin
                                    hora_d = (hora_q == C_HOUR_MAX) ? '0 : hora_q + HOUR_W'(1);
                                end else begin
                                    hora_d = (hora_q == '0) ? C_HOUR_MAX : hora_q - HOUR_W'(1);
                                end
                            end
                            FIELD_MIN: begin
                                strobe_d = 1'b1;
                                if (cmd_q == CMD_INC) begin
                                    minuto_d = (minuto_q == C_MIN_MAX) ? '0 : minuto_q + MIN_W'(1);
                                end else begin
                                    minuto_d = (minuto_q == '0) ? C_MIN_MAX : minuto_q - MIN_W'(1);
                                end
                            end
                            FIELD_SEC: begin
                                strobe_d = 1'b1;
                                if (cmd_q == CMD_INC) begin
                                    segundo_d = (segundo_q == C_SEC_MAX) ? '0 : segundo_q + SEC_W'(1);
                                end else begin
                                    segundo_d = (segundo_q == '0) ? C_SEC_MAX : segundo_q - SEC_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            ST_STROBE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ev_q      <= '0;
            cmd_q     <= CMD_NOP;
            field_q   <= FIELD_NONE;
            hora_q    <= '0;
            minuto_q  <= '0;
            segundo_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ev_q      <= ev_d;
            cmd_q     <= cmd_d;
            field_q   <= field_d;
            hora_q    <= hora_d;
            minuto_q  <= minuto_d;
            segundo_q <= segundo_d;
            strobe_q  <= strobe_d;
        end
    end

    // Capture register is frozen for the whole LOCK/EXEC/STROBE span
    assign chip_select  = (state_q != ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign field        = field_q;
    assign hora         = hora_q;
    assign minuto       = minuto_q;
    assign segundo      = segundo_q;
    assign write_strobe = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_time_set_controller.sv
// ============================================================================
// Module      : tb_time_set_controller
// Description : Randomized self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_set_controller;

    logic       clk;
    logic       reset;
    logic       aumentar;
    logic       disminuir;
    logic       funct_select;
    logic       sync_load;
    logic [4:0] hora_in;
    logic [5:0] minuto_in;
    logic [5:0] segundo_in;
    logic       chip_select;
    logic [4:0] hora;
    logic [5:0] minuto;
    logic [5:0] segundo;
    logic [1:0] field;
    logic       write_strobe;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [2:0] m_prev;
    int m_phase, m_cmd, m_field, m_h, m_m, m_s;
    bit m_strobe;

    time_set_controller #(
        .HOUR_MAX (23),
        .MIN_MAX  (59),
        .SEC_MAX  (59)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .aumentar     (aumentar),
        .disminuir    (disminuir),
        .funct_select (funct_select),
        .sync_load    (sync_load),
        .hora_in      (hora_in),
        .minuto_in    (minuto_in),
        .segundo_in   (segundo_in),
        .chip_select  (chip_select),
        .hora         (hora),
        .minuto       (minuto),
        .segundo      (segundo),
        .field        (field),
        .write_strobe (write_strobe),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 3'b000; m_phase = 0; m_cmd = 0; m_field = 0;
        m_h = 0; m_m = 0; m_s = 0; m_strobe = 1'b0;
    endtask

    function automatic int wrap(input int v, input int mx, input bit up);
        return up ? (v + 1) % (mx + 1) : (v + mx) % (mx + 1);
    endfunction

    // Command result: rise seen in idle, applied two edges later, strobed on the third
    task automatic model_edge();
        logic [2:0] in, r;
        in = {funct_select, disminuir, aumentar};
        r = in & ~m_prev;
        m_prev = in;
        m_strobe = 1'b0;
        case (m_phase)
            0: begin
                if (r != 3'b000) begin
                    m_phase = 1;
                    if (r[2])                m_cmd = 1;
                    else if (r[0] && !r[1])  m_cmd = 2;
                    else if (r[1] && !r[0])  m_cmd = 3;
                    else                     m_cmd = 0;
                end else if (sync_load && m_field == 0) begin
                    m_h = (int'(hora_in) > 23) ? 23 : int'(hora_in);
                    m_m = (int'(minuto_in) > 59) ? 59 : int'(minuto_in);
                    m_s = (int'(segundo_in) > 59) ? 59 : int'(segundo_in);
                end
            end
            1: m_phase = 2;
            2: begin
                m_phase = 3;
                if (m_cmd == 1) begin
                    m_field = (m_field + 1) % 4;
                end else if (m_cmd >= 2 && m_field != 0) begin
                    m_strobe = 1'b1;
                    if (m_field == 1) m_h = wrap(m_h, 23, m_cmd == 2);
                    if (m_field == 2) m_m = wrap(m_m, 59, m_cmd == 2);
                    if (m_field == 3) m_s = wrap(m_s, 59, m_cmd == 2);
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_all();
        check("chip_select",  chip_select,  m_phase != 0);
        check("busy",         busy,         m_phase != 0);
        check("write_strobe", write_strobe, m_strobe);
        check("field",        field,        m_field);
        check("hora",         hora,         m_h);
        check("minuto",       minuto,       m_m);
        check("segundo",      segundo,      m_s);
    endtask

    task automatic step(input logic a, input logic d, input logic f, input logic sl,
                        input int h, input int m, input int s);
        @(negedge clk);
        aumentar = a; disminuir = d; funct_select = f; sync_load = sl;
        hora_in = h[4:0]; minuto_in = m[5:0]; segundo_in = s[5:0];
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic press(input logic a, input logic d, input logic f, input int hold);
        for (int i = 0; i < hold; i++) step(a, d, f, 1'b0, 0, 0, 0);
        for (int i = 0; i < 5; i++)    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic load(input int h, input int m, input int s);
        step(1'b0, 1'b0, 1'b0, 1'b1, h, m, s);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released one cycle later
    task automatic reset_now();
        @(negedge clk);
        #2;
        reset = 1'b0;
        aumentar = 1'b0; disminuir = 1'b0; funct_select = 1'b0; sync_load = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [2:0] lv;
        reset = 1'b0;
        aumentar = 1'b0; disminuir = 1'b0; funct_select = 1'b0; sync_load = 1'b0;
        hora_in = '0; minuto_in = '0; segundo_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Select pulse: field HOUR, no strobe
        press(1'b0, 1'b0, 1'b1, 1);
        check("tp_field_hour", field, 1);
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b0, 1'b0, 1'b1, 1);
        check("tp_field_none", field, 0);

        // Wrap cases
        load(23, 0, 59);
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1'b0, 1);
        check("tp_hour_wrap", hora, 0);
        check("tp_min_keep", minuto, 0);
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b0, 1'b1, 1'b0, 1);
        check("tp_min_wrap", minuto, 59);
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1'b0, 1);
        check("tp_sec_wrap", segundo, 0);

        // Held button gives one command
        press(1'b0, 1'b0, 1'b1, 1);
        load(5, 30, 10);
        repeat (3) press(1'b0, 1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1'b0, 50);
        check("tp_hold_once", segundo, 11);
        press(1'b1, 1'b0, 1'b0, 1);
        check("tp_repress", segundo, 12);

        // Simultaneous presses
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1'b1, 1);
        check("tp_sel_prio_field", field, 2);
        check("tp_sel_prio_hora", hora, 5);
        press(1'b1, 1'b1, 1'b0, 1);
        check("tp_updown_min", minuto, 30);

        // Loads: normal, clamped, ignored
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b0, 1'b0, 1'b1, 1);
        load(12, 34, 56);
        check("tp_load_h", hora, 12);
        check("tp_load_s", segundo, 56);
        load(30, 63, 60);
        check("tp_clamp_h", hora, 23);
        check("tp_clamp_m", minuto, 59);
        press(1'b0, 1'b0, 1'b1, 1);
        load(1, 2, 3);
        check("tp_load_ignored", hora, 23);

        // Reset during EXEC
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        reset_now();
        check("tp_rst_hora", hora, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Random traffic
        lv = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) lv[b] = ~lv[b];
            end
            if ($urandom_range(0, 499) == 0) begin
                reset_now();
                lv = 3'b000;
            end else begin
                step(lv[0], lv[1], lv[2], $urandom_range(0, 4) == 0,
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/time_set_controller.md
# time_set_controller

Sequencer for manual clock-time editing. Consumes the three latched button levels (aumentar, disminuir, funct_select) from the button-capture register, drives that register's chip_select (0 = load, 1 = hold) so button values stay frozen while a command executes, and maintains the hour/minute/second set-values with field selection and wrap-around. A one-cycle write strobe hands each edited value to the RTC write path.

## Interface
- HOUR_MAX, 23, highest hour value; increment wraps to 0
- MIN_MAX, 59, highest minute value
- SEC_MAX, 59, highest second value
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed
- aumentar  in  1  latched increment button level from capture register
- disminuir  in  1  latched decrement button level
- funct_select  in  1  latched field-select button level
- sync_load  in  1  one-cycle pulse: load hora_in/minuto_in/segundo_in
- hora_in  in  5  RTC readback hours, binary
- minuto_in  in  6  RTC readback minutes, binary
- segundo_in  in  6  RTC readback seconds, binary
- chip_select  out  1  to capture register: 0 load, 1 hold
- hora  out  5  current hour set-value
- minuto  out  6  current minute set-value
- segundo  out  6  current second set-value
- field  out  2  selected field: 0 NONE, 1 HOUR, 2 MIN, 3 SEC
- write_strobe  out  1  one-cycle pulse, edited value valid
- busy  out  1  high in every state except IDLE

## Operation
- Reset (reset=0): state IDLE, field NONE, hora/minuto/segundo 0, chip_select 0, write_strobe 0, busy 0, edge history 0.
- Edge detect: prev registers sample all three inputs every cycle; event = input & ~prev. Events are acted on only in IDLE.
- FSM IDLE -> LOCK -> EXEC -> STROBE -> IDLE.
- IDLE: chip_select 0. Any event moves to LOCK.
- LOCK: chip_select 1; latch command by priority: funct_select > (aumentar xor disminuir). aumentar and disminuir both rising = no-op command.
- EXEC: chip_select 1; apply command.
  - SELECT: field NONE->HOUR->MIN->SEC->NONE.
  - INC/DEC: with field NONE, no-op. Otherwise the selected value ±1, with wrap: INC at MAX -> 0, DEC at 0 -> MAX. Other fields unchanged.
- STROBE: chip_select 1; write_strobe = 1 only if EXEC changed a value (INC/DEC with field != NONE). Next state IDLE.
- sync_load: honoured only in IDLE with field NONE and no event that cycle. It loads all three values, clamping any input above its MAX to MAX. It is ignored in every other case, and no strobe is issued.
- Holding a button produces exactly one command. Further edges need a release; the release is visible after chip_select returns to 0.
- Reset mid-sequence: immediate return to reset values. A partially executed command is discarded and no strobe is issued.

## Timing
- Event detected in IDLE at edge N -> LOCK during cycle N+1, EXEC N+2 (values update at end), STROBE N+3 (write_strobe high, new value stable on outputs), IDLE N+4.
- chip_select is high for exactly 3 cycles per command. The earliest next event is detected 2 cycles after return to IDLE: the register reloads and prev updates.
- sync_load: values update at the edge following the pulse.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package time_set_pkg: state enum (IDLE, LOCK, EXEC, STROBE), field codes, command codes (NOP, SELECT, INC, DEC), value widths.
- One sub-module: edge_detector, parameterized width, registered prev, combinational rise output. Instantiate it once with width 3.
- Wrap arithmetic stays inline as a per-field compare against MAX/0.

## Test plan
- Reset released, funct_select pulsed once -> field=1, chip_select high 3 cycles, write_strobe never asserted.
- field HOUR, hora=23, aumentar rising -> hora=0 at N+3, write_strobe single pulse at N+3, minuto and segundo unchanged.
- field MIN, minuto=0, disminuir rising -> minuto=59. Field SEC, segundo=59, aumentar -> segundo=0.
- aumentar held high 50 cycles, field SEC from 10 -> segundo=11 only. Release then press again -> 12.
- aumentar and funct_select rise same cycle in field HOUR -> field=MIN, hora unchanged, no strobe. aumentar and disminuir together -> no change, no strobe.
- sync_load with 12/34/56 in field NONE -> outputs 12/34/56. With hora_in=30 -> hora=23. Load in field HOUR -> ignored. reset asserted during EXEC -> all outputs 0, no strobe.
